// File: rtl/sram_responder.sv
// SRAM-port responder: word RAM with byte enables plus a small MMIO window
// (timer, LED, switches, simulation flag). Read data is registered, 1-cycle latency.
module sram_responder #(
  parameter int          AW        = 14,
  parameter logic [15:0] MMIO_HI   = 16'hBFAF,
  parameter logic [31:0] SIMU_INIT = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sram_en,
  input  logic [3:0]  sram_wen,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  input  logic [7:0]  switch_in,
  output logic [15:0] led_out
);

  localparam int          NUM_LANES  = 4;
  localparam logic [15:0] OFS_TIMER  = 16'hE000;
  localparam logic [15:0] OFS_LED    = 16'hF000;
  localparam logic [15:0] OFS_SWITCH = 16'hF020;
  localparam logic [15:0] OFS_SIMU   = 16'hFFFC;

  typedef struct packed {
    logic                        en;
    logic [NUM_LANES-1:0]        wen;
    logic [31:0]                 addr;
    logic [NUM_LANES-1:0][7:0]   wdata;
  } req_t;

  req_t req;
  assign req = '{en: sram_en, wen: sram_wen, addr: sram_addr, wdata: sram_wdata};

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req.addr[1:0];

  // A request during reset is dropped entirely.
  logic          mmio_sel, rd, wr;
  logic [15:0]   ofs;
  logic [AW-1:0] word_idx;
  assign mmio_sel = (req.addr[31:16] == MMIO_HI);
  assign ofs      = req.addr[15:0];
  assign word_idx = req.addr[AW+1:2];
  assign rd       = req.en && (req.wen == '0) && !rst;
  assign wr       = req.en && (req.wen != '0) && !rst;

  logic [NUM_LANES-1:0][7:0] mem [2**AW];
  logic [31:0]               timer, simu_flag;
  logic [15:0]               led;

  function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] m;
    m = cur;
    for (int i = 0; i < NUM_LANES; i++)
      if (be[i]) m[8*i +: 8] = wd[8*i +: 8];
    return m;
  endfunction

  logic [31:0] timer_m, led_m, simu_m;
  assign timer_m = merge(timer, req.wdata, req.wen);
  assign led_m   = merge({16'b0, led}, req.wdata, {2'b00, req.wen[1:0]});
  assign simu_m  = merge(simu_flag, req.wdata, req.wen);

  logic [31:0] mmio_rdata;
  always_comb begin
    mmio_rdata = '0;
    case (ofs)
      OFS_TIMER:  mmio_rdata = timer;
      OFS_LED:    mmio_rdata = {16'b0, led};
      OFS_SWITCH: mmio_rdata = {24'b0, switch_in};
      OFS_SIMU:   mmio_rdata = simu_flag;
      default:    mmio_rdata = '0;
    endcase
  end

  // RAM has no reset so it maps onto block memory.
  always_ff @(posedge clk) begin
    if (wr && !mmio_sel)
      for (int i = 0; i < NUM_LANES; i++)
        if (req.wen[i]) mem[word_idx][i] <= req.wdata[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sram_rdata <= '0;
      timer      <= '0;
      led        <= '0;
      simu_flag  <= SIMU_INIT;
    end else begin
      if (rd) sram_rdata <= mmio_sel ? mmio_rdata : 32'(mem[word_idx]);
      if (wr && mmio_sel && ofs == OFS_TIMER) timer <= timer_m;
      else                                    timer <= timer + 32'd1;
      if (wr && mmio_sel && ofs == OFS_LED)  led       <= led_m[15:0];
      if (wr && mmio_sel && ofs == OFS_SIMU) simu_flag <= simu_m;
    end
  end

  assign led_out = led;

endmodule

// File: tb/tb_sram_responder.sv
// Directed table-driven bench for sram_responder: one vector per clock edge,
// outputs compared just after the edge that consumed the vector.
module tb_sram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;
  logic [7:0]  switch_in;
  logic [15:0] led_out;

  int checks = 0;
  int errors = 0;

  sram_responder dut (
    .clk(clk), .rst(rst), .sram_en(sram_en), .sram_wen(sram_wen),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .switch_in(switch_in), .led_out(led_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  sw;
    logic [31:0] exp_rdata;
    logic [15:0] exp_led;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic r, input logic e, input logic [3:0] w,
                              input logic [31:0] a, input logic [31:0] d, input logic [7:0] s,
                              input logic [31:0] er, input logic [15:0] el);
    vec_t v;
    v.rst = r; v.en = e; v.wen = w; v.addr = a; v.wdata = d; v.sw = s;
    v.exp_rdata = er; v.exp_led = el;
    return v;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic [3:0] w,
                       input logic [31:0] a, input logic [31:0] d, input logic [7:0] s);
    @(negedge clk);
    rst = r; sram_en = e; sram_wen = w; sram_addr = a; sram_wdata = d; switch_in = s;
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] TMR  = 32'hBFAF_E000;
  localparam logic [31:0] LED  = 32'hBFAF_F000;
  localparam logic [31:0] SWA  = 32'hBFAF_F020;
  localparam logic [31:0] SIMU = 32'hBFAF_FFFC;

  initial begin
    rst = 1'b1; sram_en = 1'b0; sram_wen = '0; sram_addr = '0; sram_wdata = '0; switch_in = '0;

    //          rst  en  wen      addr          wdata         sw     exp_rdata     exp_led
    vt.push_back(mk(1, 0, 4'h0, 32'h0,        32'h0,        8'h00, 32'h0,        16'h0));
    vt.push_back(mk(1, 0, 4'h0, 32'h0,        32'h0,        8'h00, 32'h0,        16'h0));
    vt.push_back(mk(0, 1, 4'h0, SIMU,         32'h0,        8'h00, 32'hFFFF_FFFF, 16'h0));
    vt.push_back(mk(0, 1, 4'hF, 32'h10,       32'h0BAD_F00D, 8'h00, 32'hFFFF_FFFF, 16'h0));
    vt.push_back(mk(0, 1, 4'h0, 32'h10,       32'h0,        8'h00, 32'h0BAD_F00D, 16'h0));
    vt.push_back(mk(0, 1, 4'hF, 32'h100,      32'h1122_3344, 8'h00, 32'h0BAD_F00D, 16'h0));
    vt.push_back(mk(0, 1, 4'h5, 32'h100,      32'hAABB_CCDD, 8'h00, 32'h0BAD_F00D, 16'h0));
    vt.push_back(mk(0, 1, 4'h0, 32'h100,      32'h0,        8'h00, 32'h11BB_33DD, 16'h0));
    vt.push_back(mk(0, 1, 4'hF, 32'h104,      32'hCAFE_BABE, 8'h00, 32'h11BB_33DD, 16'h0));
    vt.push_back(mk(0, 1, 4'h0, 32'h104,      32'h0,        8'h00, 32'hCAFE_BABE, 16'h0));
    vt.push_back(mk(0, 0, 4'h0, 32'h104,      32'h0,        8'h00, 32'hCAFE_BABE, 16'h0));
    vt.push_back(mk(0, 1, 4'hF, TMR,          32'hFFFF_FFFE, 8'h00, 32'hCAFE_BABE, 16'h0));
    vt.push_back(mk(0, 0, 4'h0, 32'h0,        32'h0,        8'h00, 32'hCAFE_BABE, 16'h0));
    vt.push_back(mk(0, 1, 4'h0, TMR,          32'h0,        8'h00, 32'hFFFF_FFFF, 16'h0));
    vt.push_back(mk(0, 1, 4'h0, TMR,          32'h0,        8'h00, 32'h0000_0000, 16'h0));
    vt.push_back(mk(0, 1, 4'hF, LED,          32'h1234_5678, 8'h00, 32'h0,        16'h5678));
    vt.push_back(mk(0, 1, 4'h0, LED,          32'h0,        8'h00, 32'h0000_5678, 16'h5678));
    vt.push_back(mk(0, 1, 4'hC, LED,          32'hFFFF_FFFF, 8'h00, 32'h0000_5678, 16'h5678));
    vt.push_back(mk(0, 1, 4'h0, LED,          32'h0,        8'h00, 32'h0000_5678, 16'h5678));
    vt.push_back(mk(0, 1, 4'h0, SWA,          32'h0,        8'hA5, 32'h0000_00A5, 16'h5678));
    vt.push_back(mk(0, 1, 4'hF, SWA,          32'hFFFF_FFFF, 8'h3C, 32'h0000_00A5, 16'h5678));
    vt.push_back(mk(0, 1, 4'hF, 32'hBFAF_1234, 32'hFFFF_FFFF, 8'h00, 32'h0000_00A5, 16'h5678));
    vt.push_back(mk(0, 1, 4'h0, 32'hBFAF_1234, 32'h0,        8'h00, 32'h0,        16'h5678));
    vt.push_back(mk(0, 1, 4'h0, 32'h0001_0104, 32'h0,        8'h00, 32'hCAFE_BABE, 16'h5678));
    vt.push_back(mk(0, 1, 4'h3, SIMU,         32'h0000_1234, 8'h00, 32'hCAFE_BABE, 16'h5678));
    vt.push_back(mk(0, 1, 4'h0, SIMU,         32'h0,        8'h00, 32'hFFFF_1234, 16'h5678));
    vt.push_back(mk(0, 1, 4'hF, 32'h200,      32'hDEAD_BEEF, 8'h00, 32'hFFFF_1234, 16'h5678));
    vt.push_back(mk(1, 1, 4'hF, 32'h200,      32'h1111_1111, 8'h00, 32'h0,        16'h0));
    vt.push_back(mk(0, 1, 4'h0, 32'h200,      32'h0,        8'h00, 32'hDEAD_BEEF, 16'h0));
    vt.push_back(mk(0, 1, 4'h0, SIMU,         32'h0,        8'h00, 32'hFFFF_FFFF, 16'h0));

    foreach (vt[i]) begin
      drive(vt[i].rst, vt[i].en, vt[i].wen, vt[i].addr, vt[i].wdata, vt[i].sw);
      check32($sformatf("vec%0d rdata", i), sram_rdata, vt[i].exp_rdata);
      check32($sformatf("vec%0d led", i), {16'b0, led_out}, {16'b0, vt[i].exp_led});
    end

    // Timer keeps counting through idle cycles, then takes a partial byte load.
    drive(0, 1, 4'hF, TMR, 32'h0000_0010, 8'h00);
    for (int k = 0; k < 3; k++) drive(0, 0, 4'h0, 32'h0, 32'h0, 8'h00);
    drive(0, 1, 4'h0, TMR, 32'h0, 8'h00);
    check32("timer_count", sram_rdata, 32'h0000_0013);
    drive(0, 1, 4'h2, TMR, 32'h0000_5500, 8'h00);
    check32("timer_merge_hold", sram_rdata, 32'h0000_0013);
    drive(0, 1, 4'h0, TMR, 32'h0, 8'h00);
    check32("timer_merge", sram_rdata, 32'h0000_5514);

    // Reset clears the timer; the first read after reset sees 0.
    drive(1, 0, 4'h0, 32'h0, 32'h0, 8'h00);
    check32("rst_rdata", sram_rdata, 32'h0);
    drive(0, 1, 4'h0, TMR, 32'h0, 8'h00);
    check32("timer_after_rst", sram_rdata, 32'h0);
    drive(0, 1, 4'h0, TMR, 32'h0, 8'h00);
    check32("timer_after_rst_inc", sram_rdata, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Memory-side responder for the core's SRAM-style data/instruction port: it accepts en/wen/addr/wdata requests and returns rdata one cycle later.
- It combines a word-addressed RAM with byte-write enables and a small MMIO register window:
  - LED register
  - free-running timer
  - switch input
  - simulation flag
- It sits outside the core and is instantiated once per SRAM port in the SoC top and test benches.

Parameters:
- AW, 14, word-index width; RAM depth = 2^AW words (64 KB default).
- MMIO_HI, 16'hBFAF, value of addr[31:16] that selects the MMIO window instead of RAM.
- SIMU_INIT, 32'hFFFF_FFFF, reset value of the simulation flag register.

Ports:
- clk, in, 1, clock; all state changes on rising edge.
- rst, in, 1, reset, synchronous, active-high.
- sram_en, in, 1, request valid this cycle.
- sram_wen, in, 4, byte write enables; 4'b0000 with sram_en=1 means read.
- sram_addr, in, 32, byte address; bits [1:0] ignored.
- sram_wdata, in, 32, write data; byte i = bits [8i+7:8i].
- sram_rdata, out, 32, registered read data, valid the cycle after a read request.
- switch_in, in, 8, external switches; sampled combinationally at the read edge.
- led_out, out, 16, current LED register value.

Behaviour:
- Reset (rst=1 at edge):
  - sram_rdata=0, led_out=0, timer=0, simu_flag=SIMU_INIT.
  - RAM contents are not cleared.
  - A request presented during a reset cycle is dropped: no write, no read.
- Decode: mmio_sel = (sram_addr[31:16]==MMIO_HI). Otherwise RAM is selected, word index = sram_addr[AW+1:2]; higher address bits alias.
- Request types:
  - Read: sram_en=1, sram_wen=0. Latency exactly 1: the edge samples the selected word into sram_rdata.
  - Write: sram_en=1, sram_wen!=0. Only enabled bytes are updated; others are preserved. sram_rdata holds its previous value.
  - Idle: sram_en=0. No state change except the timer; sram_rdata holds.
- Back-to-back: a write at cycle N followed by a read of the same word at N+1 returns the written data at N+2. Requests are accepted every cycle; there is no stall or ready.
- MMIO offsets (sram_addr[15:0]):
  - 16'hE000 TIMER, RW 32-bit.
    - Increments by 1 every non-reset cycle, wrapping FFFF_FFFF -> 0.
    - A write cycle loads the byte-merged value (merged with the current value) instead of incrementing; counting resumes next cycle.
    - A read returns the value held before that edge's increment.
  - 16'hF000 LED, RW. Bits [15:0] are byte-writable (wen[1:0]); wen[3:2] is ignored. Reads return {16'b0, led}.
  - 16'hF020 SWITCH, RO. Reads return {24'b0, switch_in}; writes are ignored.
  - 16'hFFFC SIMU_FLAG, RW 32-bit, byte-writable.
  - Any other offset in the window reads 0; writes are ignored with no side effects.
- Behaviour is fully defined on every cycle; no X propagates to sram_rdata after reset.

Test Plan:
- Reset, then read RAM 0x0000_0010 and MMIO 0xBFAF_FFFC -> sram_rdata 0 after reset, then 0xFFFF_FFFF one cycle after the SIMU_FLAG read.
- Write 0x1122_3344 wen=1111 to 0x100, next cycle write 0xAABB_CCDD wen=0101 to 0x100, then read -> 0x11BB_33DD at the cycle after the read.
- Write 0xCAFE_BABE to 0x104, read 0x104 on the immediately following cycle -> 0xCAFE_BABE one cycle later; an idle cycle afterwards keeps sram_rdata unchanged.
- Timer checks:
  - Write 0xFFFF_FFFE to 0xBFAF_E000, then read on the 2nd cycle after the write -> 0xFFFF_FFFF.
  - A read one cycle later -> 0x0000_0000 (wrap).
- LED and switch:
  - Write 0x1234_5678 wen=1111 to 0xBFAF_F000 -> led_out=0x5678 next cycle; a read returns 0x0000_5678.
  - switch_in=0xA5, read 0xBFAF_F020 -> 0x0000_00A5.
- Reset mid-operation:
  - Assert rst together with a write to 0x200 -> RAM[0x200] unchanged, sram_rdata=0, led_out=0.
  - Unmapped MMIO 0xBFAF_1234 write then read -> 0.
